// File: rtl/srio_type9_pkg.sv
// Shared definitions for the two-source type 9 stream arbiter:
// FSM encoding, cmd bit positions and the beat layout.
package srio_type9_pkg;

    localparam int DATA_W = 64;

    localparam int CMD_START = 0;
    localparam int CMD_SRST  = 1;
    localparam int CMD_EN0   = 2;
    localparam int CMD_EN1   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic              tid;
        logic              tlast;
        logic [DATA_W-1:0] tdata;
    } beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream output register: accepts a beat whenever it is
// empty or being emptied, so throughput stays at one beat per cycle.
module axis_reg_slice
    import srio_type9_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tid,
    input  logic              i_tvalid,
    output logic              o_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tid,
    output logic              o_tvalid,
    input  logic              i_tready
);

    logic  r_valid;
    beat_t r_beat;

    assign o_tready = !r_valid || i_tready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (i_tvalid && o_tready) begin
            r_valid <= 1'b1;
            r_beat  <= '{tid: i_tid, tlast: i_tlast, tdata: i_tdata};
        end else if (i_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_tvalid = r_valid;
    assign o_tdata  = r_beat.tdata;
    assign o_tlast  = r_beat.tlast;
    assign o_tid    = r_beat.tid;

endmodule

// File: rtl/srio_type9_stream_arb.sv
// Packet-locked round-robin merge of two ad9361 type 9 streams onto one
// SRIO-bound AXI-Stream, with soft reset that never truncates a packet.
module srio_type9_stream_arb
    import srio_type9_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic              S0_AXIS_TVALID,
    input  logic              S0_AXIS_TLAST,
    output logic              S0_AXIS_TREADY,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic              S1_AXIS_TVALID,
    input  logic              S1_AXIS_TLAST,
    output logic              S1_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TID,
    input  logic              M_AXIS_TREADY,
    input  logic [31:0]       cmd,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_grant;
    logic              r_rr_prio;
    logic              r_srst_pend;

    logic [1:0]        w_s_tvalid;
    logic [1:0]        w_qual;
    logic [1:0]        w_src_done;
    logic              w_pick;
    logic              w_srst;
    logic              w_sel_valid;
    logic              w_sel_last;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_slice_in_valid;
    logic              w_slice_ready;
    logic              w_fire;
    logic              w_fire_last;
    logic              w_grant_now;
    logic              w_clear_cnt;
    logic              w_unused;

    assign w_unused   = ^cmd[31:4];
    assign w_srst     = cmd[CMD_SRST];
    assign w_s_tvalid = {S1_AXIS_TVALID, S0_AXIS_TVALID};

    for (genvar gi = 0; gi < 2; gi++) begin : g_qual
        assign w_qual[gi] = w_s_tvalid[gi] && cmd[CMD_EN0 + gi];
    end

    // Contention goes to the priority pointer, otherwise to whoever is asking.
    assign w_pick = w_qual[1] && (!w_qual[0] || r_rr_prio);

    assign w_sel_valid = r_grant ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    assign w_sel_last  = r_grant ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
    assign w_sel_data  = r_grant ? S1_AXIS_TDATA  : S0_AXIS_TDATA;

    assign w_slice_in_valid = (r_state == ST_XFER) && w_sel_valid;
    assign w_fire           = w_slice_in_valid && w_slice_ready;
    assign w_fire_last      = w_fire && w_sel_last;
    assign w_src_done       = {w_fire_last && r_grant, w_fire_last && !r_grant};
    assign w_grant_now      = (r_state == ST_ARB) && (w_state_next == ST_XFER);

    assign w_clear_cnt = (((r_state == ST_IDLE) || (r_state == ST_ARB)) && w_srst)
                       || ((r_state == ST_DRAIN) && !M_AXIS_TVALID);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_srst && cmd[CMD_START]) begin
                    w_state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                if (w_srst) begin
                    w_state_next = ST_IDLE;
                end else if (|w_qual) begin
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_fire_last) begin
                    w_state_next = (r_srst_pend || w_srst) ? ST_DRAIN : ST_ARB;
                end
            end
            ST_DRAIN: begin
                if (!M_AXIS_TVALID) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        S0_AXIS_TREADY = 1'b0;
        S1_AXIS_TREADY = 1'b0;
        busy           = 1'b0;
        case (r_state)
            ST_XFER: begin
                S0_AXIS_TREADY = !r_grant && w_slice_ready;
                S1_AXIS_TREADY = r_grant && w_slice_ready;
                busy           = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // Grant and priority move only at arbitration, which locks a packet to its source.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_grant     <= 1'b0;
            r_rr_prio   <= 1'b0;
            r_srst_pend <= 1'b0;
        end else begin
            if (w_grant_now) begin
                r_grant   <= w_pick;
                r_rr_prio <= !w_pick;
            end
            if ((r_state == ST_XFER) && w_srst) begin
                r_srst_pend <= 1'b1;
            end else if (w_state_next == ST_IDLE) begin
                r_srst_pend <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
            if (!AXIS_ARESETN) begin
                r_cnt <= '0;
            end else if (w_clear_cnt) begin
                r_cnt <= '0;
            end else if (w_src_done[gi]) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt0 = g_cnt[0].r_cnt;
    assign pkt_cnt1 = g_cnt[1].r_cnt;

    axis_reg_slice u_out_slice (
        .i_clk    (AXIS_ACLK),
        .i_rst_n  (AXIS_ARESETN),
        .i_tdata  (w_sel_data),
        .i_tlast  (w_sel_last),
        .i_tid    (r_grant),
        .i_tvalid (w_slice_in_valid),
        .o_tready (w_slice_ready),
        .o_tdata  (M_AXIS_TDATA),
        .o_tlast  (M_AXIS_TLAST),
        .o_tid    (M_AXIS_TID),
        .o_tvalid (M_AXIS_TVALID),
        .i_tready (M_AXIS_TREADY)
    );

endmodule

// File: tb/tb_srio_type9_stream_arb.sv
// Scoreboarded random bench for the two-source type 9 stream arbiter.
`timescale 1ns/1ps
module tb_srio_type9_stream_arb;

    localparam int CNT_W   = 2;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam logic [31:0] C_START = 32'h1;
    localparam logic [31:0] C_SRST  = 32'h2;
    localparam logic [31:0] C_EN0   = 32'h4;
    localparam logic [31:0] C_EN1   = 32'h8;
    localparam logic [31:0] C_ALL   = 32'hD;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        tid;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_tdata [2];
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic        m_tready;
    logic [31:0] cmd;
    wire         s0_tready, s1_tready;
    wire  [1:0]  s_tready = {s1_tready, s0_tready};
    wire  [63:0] m_tdata;
    wire         m_tvalid, m_tlast, m_tid, busy;
    wire  [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    srio_type9_stream_arb #(.CNT_W(CNT_W)) dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESETN   (rst_n),
        .S0_AXIS_TDATA  (s_tdata[0]),
        .S0_AXIS_TVALID (s_tvalid[0]),
        .S0_AXIS_TLAST  (s_tlast[0]),
        .S0_AXIS_TREADY (s0_tready),
        .S1_AXIS_TDATA  (s_tdata[1]),
        .S1_AXIS_TVALID (s_tvalid[1]),
        .S1_AXIS_TLAST  (s_tlast[1]),
        .S1_AXIS_TREADY (s1_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TID     (m_tid),
        .M_AXIS_TREADY  (m_tready),
        .cmd            (cmd),
        .pkt_cnt0       (pkt_cnt0),
        .pkt_cnt1       (pkt_cnt1),
        .busy           (busy)
    );

    beat_t src_q [2][$];
    beat_t sb [$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    mode = 0;
    bit    gap_en = 1'b0;
    bit    in_pkt [2];
    int    s_fire_cnt [2];
    int    s_first_fire = -1;
    int    m_first_valid = -1;
    int    m_beats = 0;
    int    prio_m = 0;
    int    cnt_m [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(name, act === exp, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Source and M_TREADY driver: handshakes are decided at negedge, applied after posedge.
    initial begin
        logic [1:0] fire_v;
        beat_t      b;
        s_tvalid = '0; s_tlast = '0; s_tdata[0] = '0; s_tdata[1] = '0; m_tready = 1'b1;
        in_pkt[0] = 1'b0; in_pkt[1] = 1'b0; s_fire_cnt[0] = 0; s_fire_cnt[1] = 0;
        forever begin
            @(negedge clk);
            fire_v = s_tvalid & s_tready;
            if (fire_v != 2'b00 && s_first_fire < 0) s_first_fire = cyc;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (fire_v[i] && src_q[i].size() != 0) begin
                    b = src_q[i].pop_front();
                    in_pkt[i] = !b.last;
                    s_fire_cnt[i]++;
                end
                if (!rst_n || src_q[i].size() == 0) begin
                    s_tvalid[i] = 1'b0;
                end else if (fire_v[i] || !s_tvalid[i]) begin
                    s_tvalid[i] = !(gap_en && in_pkt[i] && $urandom_range(0, 3) == 0);
                    s_tdata[i]  = src_q[i][0].data;
                    s_tlast[i]  = src_q[i][0].last;
                end
            end
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = !m_tready;
                2: m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every M-side handshake.
    initial begin
        bit          stall_prev = 1'b0;
        logic [63:0] held_data;
        logic        held_last, held_tid;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (m_tvalid && m_first_valid < 0) m_first_valid = cyc;
            if (stall_prev) begin
                chk("hold_stable", m_tvalid && m_tdata == held_data && m_tlast == held_last && m_tid == held_tid,
                    m_tdata, held_data);
            end
            if (s_tready != 2'b00) chk_eq("tready_exclusive_cnt", 64'($countones(s_tready)), 64'd1);
            if (m_tvalid && m_tready) begin
                m_beats++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 1'b0, m_tdata, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk_eq("beat_data", m_tdata, e.data);
                    chk_eq("beat_last", 64'(m_tlast), 64'(e.last));
                    chk_eq("beat_tid", 64'(m_tid), 64'(e.tid));
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held_data  = m_tdata;
            held_last  = m_tlast;
            held_tid   = m_tid;
        end
    end

    // Reference: queue all packets, then order them by the round-robin packet rule.
    task automatic run_both(input int n0, input int n1, input int len);
        beat_t lq [2][$];
        int    rem [2];
        int    g;
        beat_t b;
        rem[0] = n0;
        rem[1] = n1;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < rem[s]; p++) begin
                int l;
                l = (len > 0) ? len : int'($urandom_range(1, 6));
                for (int k = 0; k < l; k++) begin
                    b.data = {$urandom, $urandom};
                    b.last = (k == l - 1);
                    b.tid  = s[0];
                    lq[s].push_back(b);
                    src_q[s].push_back(b);
                end
            end
        end
        while (rem[0] + rem[1] > 0) begin
            g = (rem[0] > 0 && rem[1] > 0) ? prio_m : ((rem[0] > 0) ? 0 : 1);
            do begin
                b = lq[g].pop_front();
                sb.push_back(b);
            end while (!b.last);
            rem[g]--;
            cnt_m[g] = (cnt_m[g] + 1) % CNT_MOD;
            prio_m   = 1 - g;
        end
    endtask

    task automatic wait_done(input int budget, input bit with_src);
        int t;
        t = 0;
        while ((sb.size() != 0 || (with_src && (src_q[0].size() != 0 || src_q[1].size() != 0))) && t < budget) begin
            tick(1);
            t++;
        end
        chk("drain_timeout", t < budget, 64'(t), 64'(budget));
        tick(3);
    endtask

    task automatic wait_fires(input int src, input int target);
        int t;
        t = 0;
        while (s_fire_cnt[src] < target && t < 100) begin
            tick(1);
            t++;
        end
        chk("fire_wait_timeout", t < 100, 64'(s_fire_cnt[src]), 64'(target));
    endtask

    task automatic chk_cnts(input string tag);
        chk_eq({tag, "_pkt_cnt0"}, 64'(pkt_cnt0), 64'(cnt_m[0]));
        chk_eq({tag, "_pkt_cnt1"}, 64'(pkt_cnt1), 64'(cnt_m[1]));
        chk_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int    base;
        beat_t b;
        cmd = '0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk_eq("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk_eq("rst_m_tid", 64'(m_tid), 64'd0);
        chk_eq("rst_m_tdata", m_tdata, 64'd0);
        chk_eq("rst_s_tready", 64'(s_tready), 64'd0);
        chk_cnts("rst");

        // One 3-beat S0 packet, held off in IDLE until start.
        run_both(1, 0, 3);
        tick(5);
        chk_eq("idle_s_tready", 64'(s_tready), 64'd0);
        chk_eq("idle_sb_untouched", 64'(sb.size()), 64'd3);
        cmd = C_ALL;
        wait_done(200, 1'b1);
        chk_eq("first_beat_latency", 64'(m_first_valid - s_first_fire), 64'd1);
        chk_cnts("single");

        // Both sources continuously valid with 4-beat packets.
        run_both(3, 3, 4);
        wait_done(400, 1'b1);
        chk_cnts("alternate");

        // M_TREADY toggling every cycle, intra-packet source gaps.
        mode = 1;
        gap_en = 1'b1;
        run_both(3, 2, 0);
        wait_done(600, 1'b1);
        chk_cnts("toggle");

        mode = 2;
        for (int r = 0; r < 4; r++) begin
            run_both(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            wait_done(800, 1'b1);
            chk_cnts("random");
        end

        // Soft reset raised while beat 2 of a 5-beat packet is in flight.
        mode = 0;
        gap_en = 1'b0;
        base = s_fire_cnt[0];
        run_both(1, 0, 5);
        wait_fires(0, base + 2);
        cmd = C_SRST;
        tick(1);
        cmd = '0;
        wait_done(200, 1'b1);
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        chk_cnts("srst");
        chk_eq("srst_beats_all", 64'(s_fire_cnt[0] - base), 64'd5);
        run_both(0, 1, 3);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk_eq("srst_hold_tready", 64'(s_tready), 64'd0);
        end
        cmd = C_ALL;
        wait_done(200, 1'b1);
        chk_cnts("restart");

        // Enable 0 cleared mid-packet: packet finishes, further S0 packets wait.
        base = s_fire_cnt[0];
        run_both(1, 0, 4);
        wait_fires(0, base + 1);
        cmd = C_START | C_EN1;
        for (int k = 0; k < 3; k++) begin
            b.data = {$urandom, $urandom};
            b.last = (k == 2);
            b.tid  = 1'b0;
            src_q[0].push_back(b);
        end
        run_both(0, 2, 3);
        wait_done(300, 1'b0);
        chk_eq("en0_pkt_complete", 64'(s_fire_cnt[0] - base), 64'd4);
        chk_eq("en0_blocked", 64'(src_q[0].size()), 64'd3);
        for (int k = 0; k < src_q[0].size(); k++) sb.push_back(src_q[0][k]);
        cnt_m[0] = (cnt_m[0] + 1) % CNT_MOD;
        prio_m = 1;
        cmd = C_ALL;
        wait_done(200, 1'b1);
        chk_cnts("en0");

        // Counter wrap: five S1 packets on a 2-bit counter.
        cmd = C_SRST;
        tick(1);
        cmd = '0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        tick(2);
        chk_cnts("wrap_clear");
        mode = 2;
        cmd = C_ALL;
        run_both(0, 5, 0);
        wait_done(600, 1'b1);
        chk_eq("wrap_cnt1", 64'(pkt_cnt1), 64'd1);
        chk_cnts("wrap");

        // Hard reset with a beat stalled in the output register.
        mode = 3;
        for (int k = 0; k < 4; k++) begin
            b.data = {$urandom, $urandom};
            b.last = (k == 3);
            b.tid  = 1'b0;
            src_q[0].push_back(b);
        end
        tick(6);
        chk_eq("hr_stalled_valid", 64'(m_tvalid), 64'd1);
        rst_n = 1'b0;
        src_q[0].delete();
        in_pkt[0] = 1'b0;
        in_pkt[1] = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        prio_m = 0;
        tick(2);
        chk_eq("hr_m_tvalid", 64'(m_tvalid), 64'd0);
        chk_eq("hr_m_tdata", m_tdata, 64'd0);
        chk_eq("hr_s_tready", 64'(s_tready), 64'd0);
        chk_cnts("hr");
        base = m_beats;
        cmd = '0;
        mode = 0;
        rst_n = 1'b1;
        tick(8);
        chk_eq("hr_no_beats", 64'(m_beats - base), 64'd0);
        chk_eq("hr_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
